// File: rtl/cog_accumulator_fifo.sv
// Figure centre-of-gravity accumulator with size filtering and a FWFT result FIFO.
// Optional per-figure peak tracking is enabled with the COG_PEAK_EN macro.
module cog_accumulator_fifo #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned COORD_WIDTH = 11,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                                 i_sys_clk,
  input  logic                                 i_sys_aresetn,
  input  logic [DATA_WIDTH-1:0]                i_data_image,
  input  logic                                 i_data_valid,
  input  logic                                 i_start_of_fig,
  input  logic                                 i_end_of_fig,
  input  logic [COORD_WIDTH-1:0]               i_start_point_value,
  input  logic                                 i_weight_mode,
  input  logic [DATA_WIDTH-1:0]                i_threshold,
  input  logic [COORD_WIDTH-1:0]               i_min_pixels,
  input  logic [COORD_WIDTH-1:0]               i_max_pixels,
  output logic                                 o_res_valid,
  input  logic                                 i_res_ready,
  output logic [2*DATA_WIDTH+2*COORD_WIDTH-1:0] o_res_sum_ic,
  output logic [2*DATA_WIDTH+COORD_WIDTH-1:0]   o_res_sum_i,
  output logic [COORD_WIDTH-1:0]               o_res_start_point,
  output logic [COORD_WIDTH-1:0]               o_res_pixels,
`ifdef COG_PEAK_EN
  output logic [DATA_WIDTH-1:0]                o_res_peak_val,
  output logic [COORD_WIDTH-1:0]               o_res_peak_pos,
`endif
  output logic [$clog2(FIFO_DEPTH):0]          o_fifo_level,
  output logic                                 o_overflow,
  output logic [15:0]                          o_rej_cnt
);

  localparam int unsigned WW    = 2*DATA_WIDTH;
  localparam int unsigned SI_W  = 2*DATA_WIDTH + COORD_WIDTH;
  localparam int unsigned SIC_W = 2*DATA_WIDTH + 2*COORD_WIDTH;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LW    = AW + 1;
`ifdef COG_PEAK_EN
  localparam int unsigned PK_W  = DATA_WIDTH + COORD_WIDTH;
`else
  localparam int unsigned PK_W  = 0;
`endif
  // meta = {size_ok, pixels, start_point[, peak_val, peak_pos]}; entry drops size_ok
  localparam int unsigned META_W  = 1 + 2*COORD_WIDTH + PK_W;
  localparam int unsigned ENTRY_W = SIC_W + SI_W + META_W - 1;
  localparam logic [COORD_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, IN_FIG} state_t;
  state_t state, state_nxt;

  logic                   start_beat, end_beat, pix_act, fig_last, abort;
  logic                   cur_mode, size_ok;
  logic [DATA_WIDTH-1:0]  cur_thr, w_lin;
  logic [COORD_WIDTH-1:0] cur_min, cur_max, cur_start, coord, cnt_nxt;
  logic [META_W-1:0]      fe_meta;

  logic                   cfg_mode;
  logic [DATA_WIDTH-1:0]  cfg_thr;
  logic [COORD_WIDTH-1:0] cfg_min, cfg_max, cfg_start, cnt_r;
`ifdef COG_PEAK_EN
  logic [DATA_WIDTH-1:0]  pk_val_r, pk_val_nxt;
  logic [COORD_WIDTH-1:0] pk_pos_r, pk_pos_nxt;
`endif

  assign start_beat = i_data_valid & i_start_of_fig;
  assign end_beat   = i_data_valid & i_end_of_fig;

  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_beat && !end_beat) state_nxt = IN_FIG;
      IN_FIG:  if (end_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pix_act   = start_beat | ((state == IN_FIG) & i_data_valid);
    abort     = (state == IN_FIG) & start_beat;
    fig_last  = pix_act & end_beat;
    cur_mode  = start_beat ? i_weight_mode       : cfg_mode;
    cur_thr   = start_beat ? i_threshold         : cfg_thr;
    cur_min   = start_beat ? i_min_pixels        : cfg_min;
    cur_max   = start_beat ? i_max_pixels        : cfg_max;
    cur_start = start_beat ? i_start_point_value : cfg_start;
    coord     = start_beat ? '0 : cnt_r;
    if (start_beat)          cnt_nxt = COORD_WIDTH'(1);
    else if (cnt_r == CNT_MAX) cnt_nxt = cnt_r;
    else                     cnt_nxt = cnt_r + COORD_WIDTH'(1);
    size_ok = (cnt_nxt >= cur_min) && (cnt_nxt <= cur_max) && (cnt_nxt != CNT_MAX);
    w_lin   = (i_data_image > cur_thr) ? (i_data_image - cur_thr) : '0;
`ifdef COG_PEAK_EN
    if (start_beat || (i_data_image > pk_val_r)) begin
      pk_val_nxt = i_data_image;
      pk_pos_nxt = coord;
    end else begin
      pk_val_nxt = pk_val_r;
      pk_pos_nxt = pk_pos_r;
    end
    fe_meta = {size_ok, cnt_nxt, cur_start, pk_val_nxt, pk_pos_nxt};
`else
    fe_meta = {size_ok, cnt_nxt, cur_start};
`endif
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      cfg_mode  <= 1'b0;
      cfg_thr   <= '0;
      cfg_min   <= '0;
      cfg_max   <= '0;
      cfg_start <= '0;
      cnt_r     <= '0;
`ifdef COG_PEAK_EN
      pk_val_r  <= '0;
      pk_pos_r  <= '0;
`endif
    end else begin
      if (start_beat) begin
        cfg_mode  <= i_weight_mode;
        cfg_thr   <= i_threshold;
        cfg_min   <= i_min_pixels;
        cfg_max   <= i_max_pixels;
        cfg_start <= i_start_point_value;
      end
      if (pix_act) begin
        cnt_r    <= cnt_nxt;
`ifdef COG_PEAK_EN
        pk_val_r <= pk_val_nxt;
        pk_pos_r <= pk_pos_nxt;
`endif
      end
    end
  end

  logic                     s1_v, s1_first, s1_last, s1_mode;
  logic [DATA_WIDTH-1:0]    s1_w;
  logic [COORD_WIDTH-1:0]   s1_coord, s2_coord;
  logic                     s2_v, s2_first, s2_last, s3_v, s3_first, s3_last;
  logic [WW-1:0]            s2_w, s3_w;
  logic [WW+COORD_WIDTH-1:0] s3_prod;
  logic [META_W-1:0]        s1_meta, s2_meta, s3_meta;
  logic [SI_W-1:0]          acc_i, sum_i_nxt;
  logic [SIC_W-1:0]         acc_ic, sum_ic_nxt;
  logic                     accept, s4_push, s4_rej;
  logic [ENTRY_W-1:0]       s4_entry;

  always_comb begin
    sum_i_nxt  = (s3_first ? '0 : acc_i)  + SI_W'(s3_w);
    sum_ic_nxt = (s3_first ? '0 : acc_ic) + SIC_W'(s3_prod);
    accept     = s3_meta[META_W-1] && (sum_i_nxt != '0);
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      {s1_v, s1_first, s1_last, s1_mode} <= '0;
      s1_w <= '0; s1_coord <= '0; s1_meta <= '0;
      {s2_v, s2_first, s2_last} <= '0;
      s2_w <= '0; s2_coord <= '0; s2_meta <= '0;
      {s3_v, s3_first, s3_last} <= '0;
      s3_w <= '0; s3_prod <= '0; s3_meta <= '0;
      acc_i <= '0; acc_ic <= '0;
      s4_push <= 1'b0; s4_rej <= 1'b0; s4_entry <= '0;
    end else begin
      s1_v     <= pix_act;
      s1_first <= start_beat;
      s1_last  <= fig_last;
      s1_mode  <= cur_mode;
      s1_w     <= w_lin;
      s1_coord <= coord;
      s1_meta  <= fe_meta;

      s2_v     <= s1_v;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_w     <= s1_mode ? (WW'(s1_w) * WW'(s1_w)) : WW'(s1_w);
      s2_coord <= s1_coord;
      s2_meta  <= s1_meta;

      s3_v     <= s2_v;
      s3_first <= s2_first;
      s3_last  <= s2_last;
      s3_w     <= s2_w;
      s3_prod  <= (WW+COORD_WIDTH)'(s2_w) * (WW+COORD_WIDTH)'(s2_coord);
      s3_meta  <= s2_meta;

      if (s3_v) begin
        acc_i  <= sum_i_nxt;
        acc_ic <= sum_ic_nxt;
      end
      s4_push  <= s3_v & s3_last & accept;
      s4_rej   <= s3_v & s3_last & ~accept;
      s4_entry <= {sum_ic_nxt, sum_i_nxt, s3_meta[META_W-2:0]};
    end
  end

  // Aborts (front end) and late rejections (S4) can land on the same edge.
  logic [1:0]  rej_inc;
  logic [16:0] rej_sum;
  assign rej_inc = {1'b0, abort} + {1'b0, s4_rej};
  assign rej_sum = {1'b0, o_rej_cnt} + 17'(rej_inc);

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic               full, pop, do_push, drop;
  logic [ENTRY_W-1:0] head;

  assign full    = (o_fifo_level == LW'(FIFO_DEPTH));
  assign o_res_valid = (o_fifo_level != '0);
  assign pop     = o_res_valid & i_res_ready;
  assign do_push = s4_push & (~full | pop);
  assign drop    = s4_push & full & ~pop;
  assign head    = mem[rd_ptr];

  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_fifo_level <= '0;
      o_overflow   <= 1'b0;
      o_rej_cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= s4_entry;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   o_fifo_level <= o_fifo_level + LW'(1);
        2'b01:   o_fifo_level <= o_fifo_level - LW'(1);
        default: o_fifo_level <= o_fifo_level;
      endcase
      if (drop) o_overflow <= 1'b1;
      o_rej_cnt <= rej_sum[16] ? 16'hFFFF : rej_sum[15:0];
    end
  end

  assign o_res_sum_ic      = head[ENTRY_W-1 -: SIC_W];
  assign o_res_sum_i       = head[ENTRY_W-SIC_W-1 -: SI_W];
  assign o_res_pixels      = head[2*COORD_WIDTH+PK_W-1 -: COORD_WIDTH];
  assign o_res_start_point = head[COORD_WIDTH+PK_W-1 -: COORD_WIDTH];
`ifdef COG_PEAK_EN
  assign o_res_peak_val    = head[PK_W-1 -: DATA_WIDTH];
  assign o_res_peak_pos    = head[COORD_WIDTH-1:0];
`endif

endmodule
